// File: rtl/mdu_hilo.sv
// Multiply/divide unit with HI/LO registers, one-deep HI/LO backup for interrupt rollback,
// and Start/Busy outputs used by the hazard unit.
module mdu_hilo #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Instr_EX,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        IntReq,
    input  logic        remthi,
    input  logic        remtlo,
    output logic        Start,
    output logic        Busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam int unsigned MaxCycles = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CntW      = $clog2(MaxCycles + 1);

    localparam logic [5:0] FnMult  = 6'b011000;
    localparam logic [5:0] FnMultu = 6'b011001;
    localparam logic [5:0] FnDiv   = 6'b011010;
    localparam logic [5:0] FnDivu  = 6'b011011;
    localparam logic [5:0] FnMthi  = 6'b010001;
    localparam logic [5:0] FnMtlo  = 6'b010011;

    typedef enum logic [0:0] {StIdle, StRun} state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [31:0]       hi_q, hi_d;
    logic [31:0]       lo_q, lo_d;
    logic [31:0]       hi_bak_q, hi_bak_d;
    logic [31:0]       lo_bak_q, lo_bak_d;
    logic [31:0]       pend_hi_q, pend_hi_d;
    logic [31:0]       pend_lo_q, pend_lo_d;
    logic              pend_we_q, pend_we_d;

    // Decode
    logic       is_special;
    logic [5:0] func;
    logic       is_mult, is_multu, is_div, is_divu, is_mthi, is_mtlo;
    logic       is_mul_any, is_md;
    logic       unused_instr;

    assign is_special   = (Instr_EX[31:26] == 6'b000000);
    assign func         = Instr_EX[5:0];
    assign is_mult      = is_special & (func == FnMult);
    assign is_multu     = is_special & (func == FnMultu);
    assign is_div       = is_special & (func == FnDiv);
    assign is_divu      = is_special & (func == FnDivu);
    assign is_mthi      = is_special & (func == FnMthi);
    assign is_mtlo      = is_special & (func == FnMtlo);
    assign is_mul_any   = is_mult | is_multu;
    assign is_md        = is_mul_any | is_div | is_divu;
    assign unused_instr = ^Instr_EX[25:6];

    assign Busy  = (state_q == StRun);
    assign Start = is_md & ~Busy & ~IntReq;
    assign HI    = hi_q;
    assign LO    = lo_q;

    // Multiplier: sign- or zero-extend to 64 bits; the low 64 product bits are exact either way.
    logic [63:0] mul_a, mul_b, mul_p;

    always_comb begin
        mul_a = {{32{is_mult & A[31]}}, A};
        mul_b = {{32{is_mult & B[31]}}, B};
        mul_p = mul_a * mul_b;
    end

    // Divider: unsigned divide on magnitudes, then restore signs for the signed variant.
    logic        a_neg, b_neg;
    logic [31:0] a_mag, b_mag, div_den;
    logic [31:0] uq, ur, div_q, div_r;
    logic        div_by_zero;

    always_comb begin
        a_neg       = is_div & A[31];
        b_neg       = is_div & B[31];
        a_mag       = a_neg ? (32'd0 - A) : A;
        b_mag       = b_neg ? (32'd0 - B) : B;
        div_by_zero = (B == 32'd0);
        div_den     = div_by_zero ? 32'd1 : b_mag;
        uq          = a_mag / div_den;
        ur          = a_mag % div_den;
        div_q       = (a_neg ^ b_neg) ? (32'd0 - uq) : uq;
        div_r       = a_neg ? (32'd0 - ur) : ur;
    end

    // FSM and pending result
    logic commit;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pend_hi_d = pend_hi_q;
        pend_lo_d = pend_lo_q;
        pend_we_d = pend_we_q;
        commit    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (Start) begin
                    state_d = StRun;
                    if (is_mul_any) begin
                        cnt_d     = CntW'(MULT_CYCLES);
                        pend_hi_d = mul_p[63:32];
                        pend_lo_d = mul_p[31:0];
                        pend_we_d = 1'b1;
                    end else begin
                        cnt_d     = CntW'(DIV_CYCLES);
                        pend_hi_d = div_r;
                        pend_lo_d = div_q;
                        pend_we_d = ~div_by_zero;
                    end
                end
            end
            StRun: begin
                if (cnt_q == CntW'(1)) begin
                    commit  = 1'b1;
                    state_d = StIdle;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // HI/LO and backups. Rollback beats commit beats mthi/mtlo.
    logic wr_hi, wr_lo;

    always_comb begin
        wr_hi    = is_mthi & ~Busy & ~IntReq;
        wr_lo    = is_mtlo & ~Busy & ~IntReq;
        hi_d     = hi_q;
        lo_d     = lo_q;
        hi_bak_d = hi_bak_q;
        lo_bak_d = lo_bak_q;

        if (Start | wr_hi) hi_bak_d = hi_q;
        if (Start | wr_lo) lo_bak_d = lo_q;

        if (remthi) begin
            hi_d = hi_bak_q;
        end else if (commit & pend_we_q) begin
            hi_d = pend_hi_q;
        end else if (wr_hi) begin
            hi_d = A;
        end

        if (remtlo) begin
            lo_d = lo_bak_q;
        end else if (commit & pend_we_q) begin
            lo_d = pend_lo_q;
        end else if (wr_lo) begin
            lo_d = A;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            hi_bak_q  <= '0;
            lo_bak_q  <= '0;
            pend_hi_q <= '0;
            pend_lo_q <= '0;
            pend_we_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            hi_bak_q  <= hi_bak_d;
            lo_bak_q  <= lo_bak_d;
            pend_hi_q <= pend_hi_d;
            pend_lo_q <= pend_lo_d;
            pend_we_q <= pend_we_d;
        end
    end

endmodule

// File: tb/tb_mdu_hilo.sv
// Bench for mdu_hilo: behavioural model checked every cycle, plus directed literal checks.
module tb_mdu_hilo;

    localparam logic [5:0] FMULT  = 6'b011000;
    localparam logic [5:0] FMULTU = 6'b011001;
    localparam logic [5:0] FDIV   = 6'b011010;
    localparam logic [5:0] FDIVU  = 6'b011011;
    localparam logic [5:0] FMTHI  = 6'b010001;
    localparam logic [5:0] FMTLO  = 6'b010011;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] Instr_EX = 32'd0;
    logic [31:0] A = 32'd0;
    logic [31:0] B = 32'd0;
    logic        IntReq = 1'b0;
    logic        remthi = 1'b0;
    logic        remtlo = 1'b0;
    logic        Start, Busy;
    logic [31:0] HI, LO;

    int total = 0;
    int bad   = 0;
    logic chk_en = 1'b0;
    logic done   = 1'b0;

    always #5 clk = ~clk;

    mdu_hilo #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk     (clk),
        .reset   (reset),
        .Instr_EX(Instr_EX),
        .A       (A),
        .B       (B),
        .IntReq  (IntReq),
        .remthi  (remthi),
        .remtlo  (remtlo),
        .Start   (Start),
        .Busy    (Busy),
        .HI      (HI),
        .LO      (LO)
    );

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
        logic [31:0] hbak;
        logic [31:0] lbak;
        logic [31:0] phi;
        logic [31:0] plo;
        logic        pwe;
        logic [7:0]  left;
    } model_t;

    model_t m;

    function automatic logic is_md_op(input logic [31:0] ins);
        return (ins[31:26] == 6'd0) && (ins[5:0] inside {FMULT, FMULTU, FDIV, FDIVU});
    endfunction

    // One clock edge of architectural behaviour, written from the operation rules.
    function automatic model_t next_model(input model_t s, input logic [31:0] ins,
                                          input logic [31:0] a, input logic [31:0] b,
                                          input logic irq, input logic rh, input logic rl);
        model_t n;
        longint sq, sr;
        logic [5:0] f;
        n = s;
        f = ins[5:0];
        if (s.left == 8'd0) begin
            if (ins[31:26] == 6'd0 && !irq) begin
                if (is_md_op(ins)) begin
                    n.hbak = s.hi;
                    n.lbak = s.lo;
                    n.pwe  = 1'b1;
                    n.left = (f == FMULT || f == FMULTU) ? 8'd5 : 8'd10;
                    case (f)
                        FMULT:  {n.phi, n.plo} = longint'($signed(a)) * longint'($signed(b));
                        FMULTU: {n.phi, n.plo} = {32'd0, a} * {32'd0, b};
                        FDIV: begin
                            if (b == 32'd0) begin
                                n.pwe = 1'b0;
                            end else begin
                                sq = longint'($signed(a)) / longint'($signed(b));
                                sr = longint'($signed(a)) % longint'($signed(b));
                                n.plo = sq[31:0];
                                n.phi = sr[31:0];
                            end
                        end
                        default: begin
                            if (b == 32'd0) begin
                                n.pwe = 1'b0;
                            end else begin
                                n.plo = a / b;
                                n.phi = a % b;
                            end
                        end
                    endcase
                end else if (f == FMTHI) begin
                    n.hbak = s.hi;
                    n.hi   = a;
                end else if (f == FMTLO) begin
                    n.lbak = s.lo;
                    n.lo   = a;
                end
            end
        end else begin
            if (s.left == 8'd1 && s.pwe) begin
                n.hi = s.phi;
                n.lo = s.plo;
            end
            n.left = s.left - 8'd1;
        end
        if (rh) n.hi = s.hbak;
        if (rl) n.lo = s.lbak;
        return n;
    endfunction

    always @(posedge clk or posedge reset) begin
        if (reset) m <= '0;
        else       m <= next_model(m, Instr_EX, A, B, IntReq, remthi, remtlo);
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h, want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model
    initial begin
        wait (chk_en);
        forever begin
            @(negedge clk);
            if (done) break;
            chk("model_busy", {31'd0, Busy}, {31'd0, m.left != 8'd0});
            chk("model_start", {31'd0, Start},
                {31'd0, is_md_op(Instr_EX) && (m.left == 8'd0) && !IntReq});
            chk("model_hi", HI, m.hi);
            chk("model_lo", LO, m.lo);
        end
    end

    function automatic logic [31:0] rtype(input logic [5:0] f);
        return {26'd0, f};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Count Busy cycles after a launch edge, bounded.
    task automatic count_busy(output int n);
        n = 0;
        while (Busy && n < 40) begin
            n++;
            step();
        end
    endtask

    task automatic launch(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                          input string name);
        Instr_EX = rtype(f);
        A = a;
        B = b;
        #1;
        chk({name, "_start"}, {31'd0, Start}, 32'd1);
        step();
        Instr_EX = 32'd0;
    endtask

    int n;

    initial begin
        #1 reset = 1'b1;
        chk_en = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        chk("rst_hi", HI, 32'd0);
        chk("rst_lo", LO, 32'd0);
        chk("rst_busy", {31'd0, Busy}, 32'd0);

        launch(FMULT, 32'hFFFF_FFFE, 32'd3, "mult");
        chk("mult_start_once", {31'd0, Start}, 32'd0);
        count_busy(n);
        chk("mult_busy_len", n, 32'd5);
        chk("mult_hi", HI, 32'hFFFF_FFFF);
        chk("mult_lo", LO, 32'hFFFF_FFFA);

        launch(FMULTU, 32'hFFFF_FFFE, 32'd3, "multu");
        count_busy(n);
        chk("multu_busy_len", n, 32'd5);
        chk("multu_hi", HI, 32'h0000_0002);
        chk("multu_lo", LO, 32'hFFFF_FFFA);

        launch(FDIV, 32'hFFFF_FFF9, 32'd2, "div");
        count_busy(n);
        chk("div_busy_len", n, 32'd10);
        chk("div_lo", LO, 32'hFFFF_FFFD);
        chk("div_hi", HI, 32'hFFFF_FFFF);

        launch(FDIVU, 32'd7, 32'd0, "divu0");
        count_busy(n);
        chk("divu0_busy_len", n, 32'd10);
        chk("divu0_hi", HI, 32'hFFFF_FFFF);
        chk("divu0_lo", LO, 32'hFFFF_FFFD);

        launch(FDIV, 32'h8000_0000, 32'hFFFF_FFFF, "divovf");
        count_busy(n);
        chk("divovf_lo", LO, 32'h8000_0000);
        chk("divovf_hi", HI, 32'h0000_0000);

        // Rollback of mthi while an mtlo sits in EX under the interrupt
        Instr_EX = rtype(FMTHI); A = 32'h1111_1111; step();
        A = 32'h2222_2222; step();
        chk("mthi_hi", HI, 32'h2222_2222);
        Instr_EX = rtype(FMTLO); A = 32'h3333_3333; IntReq = 1'b1; remthi = 1'b1; step();
        chk("remthi_hi", HI, 32'h1111_1111);
        chk("remthi_lo", LO, 32'h8000_0000);
        IntReq = 1'b0; remthi = 1'b0;
        A = 32'h4444_4444; step();
        chk("mtlo_lo", LO, 32'h4444_4444);
        Instr_EX = 32'd0; IntReq = 1'b1; remtlo = 1'b1; step();
        chk("remtlo_lo", LO, 32'h8000_0000);
        IntReq = 1'b0; remtlo = 1'b0;

        // mthi held in EX during a mult, with an interrupt pulse mid-run
        launch(FMULT, 32'd3, 32'd5, "mult2");
        Instr_EX = rtype(FMTHI); A = 32'hDEAD_BEEF;
        n = 0;
        while (Busy && n < 40) begin
            IntReq = (n == 2);
            n++;
            step();
        end
        IntReq = 1'b0;
        chk("mult2_busy_len", n, 32'd5);
        chk("mult2_hi", HI, 32'd0);
        chk("mult2_lo", LO, 32'd15);
        launch(FDIV, 32'd100, 32'd7, "b2b_div");
        count_busy(n);
        chk("b2b_div_busy_len", n, 32'd10);
        chk("b2b_div_lo", LO, 32'd14);
        chk("b2b_div_hi", HI, 32'd2);

        // Asynchronous reset in cycle 3 of a div
        launch(FDIV, 32'd100, 32'd3, "rst_div");
        step();
        step();
        chk("rst_div_busy_pre", {31'd0, Busy}, 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("rst_div_busy_async", {31'd0, Busy}, 32'd0);
        step();
        step();
        reset = 1'b0;
        step();
        chk("rst_div_hi", HI, 32'd0);
        chk("rst_div_lo", LO, 32'd0);
        chk("rst_div_busy", {31'd0, Busy}, 32'd0);

        step();
        done = 1'b1;
        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
